// File: rtl/n2_wb_redirect_if.sv
// Execute-to-writeback result bus: one retiring instruction per cycle,
// with optional control-flow redirect request.
interface n2_wb_redirect_if #(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned UID_W     = 8
);
  logic                 ex_v_i;
  logic [UID_W-1:0]     ex_uid_i;
  logic [31:0]          ex_pc_i;
  logic                 ex_rf_we_i;
  logic [REG_IDX_W-1:0] ex_rf_dst_i;
  logic [31:0]          ex_rst_i;
  logic                 ex_is_branch_i;
  logic [31:0]          ex_branch_pc_i;

  modport master (
    output ex_v_i, ex_uid_i, ex_pc_i, ex_rf_we_i, ex_rf_dst_i,
           ex_rst_i, ex_is_branch_i, ex_branch_pc_i
  );
  modport slave (
    input  ex_v_i, ex_uid_i, ex_pc_i, ex_rf_we_i, ex_rf_dst_i,
           ex_rst_i, ex_is_branch_i, ex_branch_pc_i
  );
endinterface

// File: rtl/n2_wb_redirect.sv
// Writeback/redirect stage: registers execute results into the RF write port,
// retires them, and squashes wrong-path results until fetch acknowledges a redirect.
module n2_wb_redirect #(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned UID_W     = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  n2_wb_redirect_if.slave      ex,
  input  logic                 fetch_ack_i,
  output logic                 rf_we_o,
  output logic [REG_IDX_W-1:0] rf_waddr_o,
  output logic [31:0]          rf_wdata_o,
  output logic                 byp_v_o,
  output logic [REG_IDX_W-1:0] byp_dst_o,
  output logic [31:0]          byp_data_o,
  output logic                 redirect_v_o,
  output logic [31:0]          redirect_pc_o,
  output logic                 flush_o,
  output logic                 retire_v_o,
  output logic [UID_W-1:0]     retire_uid_o,
  output logic [31:0]          retire_pc_o,
  output logic [31:0]          instret_o
);

  typedef enum logic [1:0] {RUN, REDIR, DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_nx;
  logic                 w_accept;
  logic                 w_rf_we;
  logic                 w_redir_v;
  logic                 w_flush;

  logic                 r_rf_we;
  logic [REG_IDX_W-1:0] r_waddr;
  logic [31:0]          r_wdata;
  logic                 r_redir_v;
  logic [31:0]          r_redir_pc;
  logic                 r_flush;
  logic                 r_retire_v;
  logic [UID_W-1:0]     r_retire_uid;
  logic [31:0]          r_retire_pc;
  logic [31:0]          r_instret;

  assign w_accept = ex.ex_v_i && (r_state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= RUN;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      RUN:     if (w_accept && ex.ex_is_branch_i) w_state_nx = REDIR;
      REDIR:   w_state_nx = fetch_ack_i ? RUN : DRAIN;
      DRAIN:   if (fetch_ack_i) w_state_nx = RUN;
      default: w_state_nx = RUN;
    endcase
  end

  // Flush is registered from the next state so it covers REDIR and DRAIN exactly.
  always_comb begin
    w_rf_we   = w_accept && ex.ex_rf_we_i && (ex.ex_rf_dst_i != '0);
    w_redir_v = w_accept && ex.ex_is_branch_i;
    w_flush   = (w_state_nx != RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rf_we      <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_redir_v    <= 1'b0;
      r_redir_pc   <= '0;
      r_flush      <= 1'b0;
      r_retire_v   <= 1'b0;
      r_retire_uid <= '0;
      r_retire_pc  <= '0;
      r_instret    <= '0;
    end else begin
      r_rf_we    <= w_rf_we;
      r_redir_v  <= w_redir_v;
      r_flush    <= w_flush;
      r_retire_v <= w_accept;
      if (w_accept) begin
        r_waddr      <= ex.ex_rf_dst_i;
        r_wdata      <= ex.ex_rst_i;
        r_retire_uid <= ex.ex_uid_i;
        r_retire_pc  <= ex.ex_pc_i;
        r_instret    <= r_instret + 32'd1;
      end
      if (w_redir_v) r_redir_pc <= ex.ex_branch_pc_i;
    end
  end

  assign rf_we_o       = r_rf_we;
  assign rf_waddr_o    = r_waddr;
  assign rf_wdata_o    = r_wdata;
  assign byp_v_o       = r_rf_we;
  assign byp_dst_o     = r_waddr;
  assign byp_data_o    = r_wdata;
  assign redirect_v_o  = r_redir_v;
  assign redirect_pc_o = r_redir_pc;
  assign flush_o       = r_flush;
  assign retire_v_o    = r_retire_v;
  assign retire_uid_o  = r_retire_uid;
  assign retire_pc_o   = r_retire_pc;
  assign instret_o     = r_instret;

endmodule

// File: tb/tb_n2_wb_redirect.sv
// Scoreboard bench for n2_wb_redirect: stimulus pushes expected outputs from a
// "blocked until fetch ack" reference model; a monitor pops and compares each cycle.
module tb_n2_wb_redirect;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fetch_ack_i;
  logic        rf_we_o, byp_v_o, redirect_v_o, flush_o, retire_v_o;
  logic [4:0]  rf_waddr_o, byp_dst_o;
  logic [31:0] rf_wdata_o, byp_data_o, redirect_pc_o, retire_pc_o, instret_o;
  logic [7:0]  retire_uid_o;

  always #5 clk = ~clk;

  n2_wb_redirect_if #(.REG_IDX_W(5), .UID_W(8)) exif ();

  n2_wb_redirect #(.REG_IDX_W(5), .UID_W(8)) dut (
    .clk(clk), .resetn(resetn), .ex(exif), .fetch_ack_i(fetch_ack_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .byp_v_o(byp_v_o), .byp_dst_o(byp_dst_o), .byp_data_o(byp_data_o),
    .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .retire_v_o(retire_v_o), .retire_uid_o(retire_uid_o), .retire_pc_o(retire_pc_o),
    .instret_o(instret_o)
  );

  typedef struct {
    logic        ret;
    logic [7:0]  uid;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] rpc;
    logic        flush;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: after a taken branch retires, nothing is accepted until fetch acks.
  bit          m_blocked = 1'b0;
  logic [31:0] m_cnt = '0, m_rpc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("retire_v", 32'(retire_v_o), 32'(e.ret));
      chk("rf_we", 32'(rf_we_o), 32'(e.we));
      chk("byp_v", 32'(byp_v_o), 32'(e.we));
      chk("redirect_v", 32'(redirect_v_o), 32'(e.redir));
      chk("redirect_pc", redirect_pc_o, e.rpc);
      chk("flush", 32'(flush_o), 32'(e.flush));
      chk("instret", instret_o, e.cnt);
      if (e.ret) begin
        chk("retire_uid", 32'(retire_uid_o), 32'(e.uid));
        chk("retire_pc", retire_pc_o, e.pc);
      end
      if (e.we) begin
        chk("rf_waddr", 32'(rf_waddr_o), 32'(e.waddr));
        chk("rf_wdata", rf_wdata_o, e.wdata);
        chk("byp_dst", 32'(byp_dst_o), 32'(e.waddr));
        chk("byp_data", byp_data_o, e.wdata);
      end
    end
  end

  // Called just after a negedge: drive one cycle of inputs, predict, wait a cycle.
  task automatic cyc(input bit v, input logic [7:0] uid, input logic [31:0] pc,
                     input bit we, input logic [4:0] dst, input logic [31:0] data,
                     input bit br, input logic [31:0] bpc, input bit ack);
    exp_t e;
    bit acc;
    exif.ex_v_i = v;         exif.ex_uid_i = uid;      exif.ex_pc_i = pc;
    exif.ex_rf_we_i = we;    exif.ex_rf_dst_i = dst;   exif.ex_rst_i = data;
    exif.ex_is_branch_i = br; exif.ex_branch_pc_i = bpc; fetch_ack_i = ack;
    e = '{default: '0};
    if (!resetn) begin
      m_blocked = 1'b0; m_cnt = '0; m_rpc = '0;
    end else begin
      acc = v && !m_blocked;
      e.ret = acc; e.uid = uid; e.pc = pc;
      e.we = acc && we && (dst != 5'd0);
      e.waddr = dst; e.wdata = data;
      e.redir = acc && br;
      if (acc) m_cnt = m_cnt + 32'd1;
      if (acc && br) begin
        m_rpc = bpc; m_blocked = 1'b1;
      end else if (m_blocked && ack) begin
        m_blocked = 1'b0;
      end
      e.rpc = m_rpc; e.flush = m_blocked; e.cnt = m_cnt;
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit ack);
    cyc(1'b0, 8'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, ack);
  endtask

  task automatic alu(input logic [7:0] uid, input logic [4:0] dst, input logic [31:0] data);
    cyc(1'b1, uid, 32'h1000 + 32'(uid) * 4, 1'b1, dst, data, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    idle(1'b0);
    idle(1'b0);
    resetn = 1'b1;
    alu(8'd3, 5'd5, 32'h1234);
    alu(8'd4, 5'd0, 32'hdead);
    alu(8'd5, 5'd31, 32'hcafe_f00d);
    // branch uid 7 -> 0x200; uids 8/9 squashed; ack on 3rd cycle after
    cyc(1'b1, 8'd7, 32'h100, 1'b0, 5'd0, 32'd0, 1'b1, 32'h200, 1'b0);
    alu(8'd8, 5'd6, 32'h8);
    alu(8'd9, 5'd7, 32'h9);
    idle(1'b1);
    alu(8'd10, 5'd8, 32'ha);
    // ack during the redirect cycle itself
    cyc(1'b1, 8'd11, 32'h110, 1'b1, 5'd1, 32'h11, 1'b1, 32'h300, 1'b0);
    cyc(1'b1, 8'd12, 32'h120, 1'b0, 5'd0, 32'd0, 1'b1, 32'h400, 1'b1);
    alu(8'd13, 5'd9, 32'hd);
    // counter wrap
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    m_cnt = 32'hFFFF_FFFF;
    chk("instret_preload", instret_o, 32'hFFFF_FFFF);
    idle(1'b0);
    alu(8'd14, 5'd10, 32'he);
    // reset asserted while draining
    cyc(1'b1, 8'd15, 32'h150, 1'b0, 5'd0, 32'd0, 1'b1, 32'h500, 1'b0);
    idle(1'b0);
    idle(1'b0);
    resetn = 1'b0;
    #1;
    chk("flush_async_rst", 32'(flush_o), 32'd0);
    chk("instret_async_rst", instret_o, 32'd0);
    chk("redirect_pc_async_rst", redirect_pc_o, 32'd0);
    chk("retire_uid_async_rst", 32'(retire_uid_o), 32'd0);
    idle(1'b0);
    resetn = 1'b1;
    alu(8'd16, 5'd11, 32'h16);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom, 1'($urandom),
          5'($urandom), $urandom, $urandom_range(0, 9) < 2, $urandom,
          $urandom_range(0, 3) == 0);
    end
    idle(1'b1);
    idle(1'b0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/n2_wb_redirect.md
# n2_wb_redirect

Writeback / redirect stage directly downstream of the execute stage in the NanoCore two-issue pipeline. It registers each execute result into the register-file write port, retires the instruction, and turns a mispredict/taken-branch indication into a one-cycle fetch redirect. It then squashes wrong-path results until fetch confirms the restart. It also drives a WB-stage forwarding port and a retired-instruction counter.

## Interface
- REG_IDX_W, 5, register index width
- UID_W, 8, instruction uid width
- clk  in  1  clock
- resetn  in  1  reset; resetn asynchronous, active-low; clock clk
- ex_v_i  in  1  execute result valid this cycle
- ex_uid_i  in  UID_W  uid of execute result
- ex_pc_i  in  32  pc of execute result
- ex_rf_we_i  in  1  result writes register file
- ex_rf_dst_i  in  REG_IDX_W  destination register
- ex_rst_i  in  32  result data
- ex_is_branch_i  in  1  control flow must be redirected
- ex_branch_pc_i  in  32  redirect target
- fetch_ack_i  in  1  fetch has restarted at redirect target (pulse)
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  REG_IDX_W  write address
- rf_wdata_o  out  32  write data
- byp_v_o / byp_dst_o / byp_data_o  out  1 / REG_IDX_W / 32  forwarding copy of the write port
- redirect_v_o  out  1  fetch redirect pulse
- redirect_pc_o  out  32  redirect target
- flush_o  out  1  kill all upstream in-flight instructions
- retire_v_o / retire_uid_o / retire_pc_o  out  1 / UID_W / 32  retirement record
- instret_o  out  32  retired-instruction count

## Operation
- States: RUN, REDIR, DRAIN. Reset state is RUN.
- An instruction is accepted when ex_v_i=1 and state=RUN. In REDIR and DRAIN, ex_v_i is discarded: no write, no retire, no count.
- Accepted instruction:
  - retire_v_o=1 with its uid and pc.
  - rf_we_o=ex_rf_we_i && (ex_rf_dst_i!=0); x0 writes are suppressed.
  - rf_waddr_o/rf_wdata_o take dst/result.
  - instret_o increments by 1 and wraps at 2^32.
- Accepted with ex_is_branch_i=1:
  - The instruction itself retires and writes normally.
  - Next cycle: redirect_v_o=1, redirect_pc_o=ex_branch_pc_i, flush_o=1.
  - State goes RUN→REDIR.
- REDIR lasts one cycle, then state goes to DRAIN. If fetch_ack_i=1 in the REDIR cycle, state goes to RUN instead.
- DRAIN: flush_o stays 1. Leave for RUN on the cycle after fetch_ack_i=1.
- fetch_ack_i is ignored in RUN.
- No timeout; DRAIN holds indefinitely until fetch_ack_i.
- redirect_pc_o holds its last value when redirect_v_o=0.
- byp_* mirrors rf_we_o/rf_waddr_o/rf_wdata_o exactly.

## Timing
- All outputs are registered. Latency from an ex_* input to rf_we_o/retire_v_o: 1 cycle.
- Latency from a branch input to redirect_v_o/flush_o: 1 cycle, the same cycle the branch retires.
- redirect_v_o is high for exactly one cycle per accepted branch.
- flush_o is high from the REDIR cycle through the DRAIN cycle in which fetch_ack_i is seen. It falls on the following cycle.
- Reset values:
  - rf_we_o=0, byp_v_o=0, retire_v_o=0, redirect_v_o=0, flush_o=0, instret_o=0.
  - rf_waddr_o=0, rf_wdata_o=0, redirect_pc_o=0, retire_uid_o=0, retire_pc_o=0.
- Reset asserted mid-DRAIN: all outputs return to reset values immediately and state returns to RUN.
- Back-to-back accepted instructions: one per cycle, no bubbles.
- A branch arriving in the same cycle as the previous redirect (REDIR state) is discarded.

## Test plan
- Reset, then ex_v_i=1, rf_we=1, dst=5, rst=0x1234, uid=3 → next cycle rf_we_o=1, waddr=5, wdata=0x1234, retire_uid=3, instret_o=1.
- ex_v_i=1, rf_we=1, dst=0 → rf_we_o=0, byp_v_o=0, retire_v_o=1, instret increments.
- Branch at uid=7 with target 0x200, then ex_v_i on uid 8/9 over the next 2 cycles, fetch_ack_i on cycle 3 → redirect_v_o=1 for one cycle with pc 0x200; uids 8/9 never retire; flush_o high for 3 cycles; next ex_v_i is accepted.
- Branch with fetch_ack_i in the REDIR cycle → flush_o high for exactly 1 cycle; an instruction arriving 2 cycles after the branch is accepted.
- Preload instret_o to 0xFFFFFFFF via 2^32−1 retirements (or force), then retire one more → instret_o=0.
- resetn pulsed low during DRAIN → flush_o=0 immediately; after release, ex_v_i is accepted without fetch_ack_i.
